load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one memory operation at a time over a req/gnt + rvalid data port,
// with lane steering for stores, sign/zero extension for loads and alignment fault detection.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ex_valid,
    output logic            o_ex_ready,
    input  logic [XLEN-1:0] i_ex_addr,
    input  logic [XLEN-1:0] i_ex_wdata,
    input  logic [2:0]      i_ex_funct3,
    input  logic            i_ex_rd,
    input  logic            i_ex_wr,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_wstrb,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    input  logic            i_wb_ready,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [2:0]      funct3_q;
    logic            rd_q, wr_q;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            fault_q, fault_d;
    logic            capture;
    logic            in_req;

    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off,
                                          input logic rd, input logic wr);
        logic bad_op;
        logic misaligned;
        bad_op = 1'b0;
        if (rd && wr)
            bad_op = 1'b1;
        else if (rd)
            bad_op = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        else if (wr)
            bad_op = f3[2] || (f3[1:0] == 2'b11);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return bad_op || ((rd || wr) && misaligned);
    endfunction

    // funct3[2] selects zero extension (LBU/LHU); LW passes the word through.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
        logic [7:0]      lane_b;
        logic [15:0]     lane_h;
        logic [XLEN-1:0] result;
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = rdata[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  result = {{(XLEN-8){lane_b[7]}}, lane_b};
            3'b001:  result = {{(XLEN-16){lane_h[15]}}, lane_h};
            3'b100:  result = {{(XLEN-8){1'b0}}, lane_b};
            3'b101:  result = {{(XLEN-16){1'b0}}, lane_h};
            default: result = rdata;
        endcase
        return result;
    endfunction

    function automatic logic [XLEN-1:0] store_replicate(input logic [XLEN-1:0] wdata,
                                                        input logic [2:0] f3);
        logic [XLEN-1:0] result;
        case (f3[1:0])
            2'b00:   result = {(XLEN/8){wdata[7:0]}};
            2'b01:   result = {(XLEN/16){wdata[15:0]}};
            default: result = wdata;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off,
                                                input logic wr);
        logic [3:0] result;
        if (!wr)
            result = 4'b0000;
        else begin
            case (f3[1:0])
                2'b00:   result = 4'b0001 << off;
                2'b01:   result = 4'b0011 << off;
                default: result = 4'b1111;
            endcase
        end
        return result;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wb_data_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            fault_q   <= fault_d;
            if (capture) begin
                addr_q   <= i_ex_addr;
                wdata_q  <= i_ex_wdata;
                funct3_q <= i_ex_funct3;
                rd_q     <= i_ex_rd;
                wr_q     <= i_ex_wr;
            end
        end
    end

    // Pass-through and faulting operations skip the memory port and complete from IDLE.
    always_comb begin
        state_d   = state_q;
        wb_data_d = wb_data_q;
        fault_d   = fault_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ex_valid) begin
                    capture = 1'b1;
                    if (!i_ex_rd && !i_ex_wr) begin
                        state_d   = DONE;
                        wb_data_d = i_ex_addr;
                        fault_d   = 1'b0;
                    end else if (access_fault(i_ex_funct3, i_ex_addr[1:0], i_ex_rd, i_ex_wr)) begin
                        state_d   = DONE;
                        wb_data_d = '0;
                        fault_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (i_dmem_gnt)
                    state_d = WAIT;
            end
            WAIT: begin
                if (i_dmem_rvalid) begin
                    state_d   = DONE;
                    wb_data_d = wr_q ? '0 : load_extract(i_dmem_rdata, addr_q[1:0], funct3_q);
                    fault_d   = 1'b0;
                end
            end
            DONE: begin
                if (i_wb_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_req       = (state_q == REQ);
    assign o_ex_ready   = (state_q == IDLE);
    assign o_dmem_req   = in_req;
    assign o_dmem_we    = in_req && wr_q;
    assign o_dmem_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign o_dmem_wdata = in_req ? store_replicate(wdata_q, funct3_q) : '0;
    assign o_dmem_wstrb = in_req ? store_strobe(funct3_q, addr_q[1:0], wr_q) : 4'b0000;
    assign o_wb_valid   = (state_q == DONE);
    assign o_wb_data    = wb_data_q;
    assign o_fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized operations
// checked against an arithmetic reference model of the access rules.
module tb_load_store_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_addr, ex_wdata;
    logic [2:0]      ex_funct3;
    logic            ex_rd, ex_wr;
    logic            dmem_req, dmem_we;
    logic [XLEN-1:0] dmem_addr, dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_valid, wb_ready;
    logic [XLEN-1:0] wb_data;
    logic            fault;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_op
    bit              obs_req_seen, obs_unstable, obs_req_late, obs_timeout;
    bit              obs_held_bad, obs_rdy_busy, obs_idle_ok;
    int              obs_lat;
    logic [XLEN-1:0] obs_addr, obs_wdata, obs_wb_data;
    logic            obs_we, obs_fault;
    logic [3:0]      obs_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(XLEN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ex_valid   (ex_valid),
        .o_ex_ready   (ex_ready),
        .i_ex_addr    (ex_addr),
        .i_ex_wdata   (ex_wdata),
        .i_ex_funct3  (ex_funct3),
        .i_ex_rd      (ex_rd),
        .i_ex_wr      (ex_wr),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_wstrb (dmem_wstrb),
        .i_dmem_gnt   (dmem_gnt),
        .i_dmem_rvalid(dmem_rvalid),
        .i_dmem_rdata (dmem_rdata),
        .o_wb_valid   (wb_valid),
        .i_wb_ready   (wb_ready),
        .o_wb_data    (wb_data),
        .o_fault      (fault)
    );

    // Reference model: derives the expected outcome from the access rules directly.
    function automatic void model(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input logic [2:0] f3,
                                  input logic rd, input logic wr,
                                  output logic e_fault, output logic e_mem,
                                  output logic [31:0] e_wb, output logic [31:0] e_daddr,
                                  output logic [31:0] e_dwdata, output logic [3:0] e_wstrb);
        int     size, off;
        bit     legal;
        longint one, v;
        one = 1;
        off = int'(addr[1:0]);
        case (f3[1:0])
            2'd0: size = 1;
            2'd1: size = 2;
            2'd2: size = 4;
            default: size = 0;
        endcase
        e_fault = 1'b0; e_mem = 1'b0; e_wb = '0; e_daddr = '0; e_dwdata = '0; e_wstrb = '0;
        if (!rd && !wr) begin
            e_wb = addr;
            return;
        end
        legal = !(rd && wr) && size != 0 &&
                (rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2}));
        if (legal && (off % size) != 0) legal = 0;
        if (!legal) begin
            e_fault = 1'b1;
            return;
        end
        e_mem   = 1'b1;
        e_daddr = addr - 32'(off);
        e_wstrb = wr ? 4'(((1 << size) - 1) << off) : 4'b0000;
        for (int lane = 0; lane < 4; lane++)
            e_dwdata[8*lane +: 8] = wdata[8*(lane % size) +: 8];
        if (wr) begin
            e_wb = '0;
        end else begin
            v = longint'(rdata >> (8 * off)) & ((one << (8 * size)) - 1);
            if (!f3[2] && size < 4 && v >= (one << (8 * size - 1)))
                v = v - (one << (8 * size));
            e_wb = v[31:0];
        end
    endfunction

    // Drives one operation end to end, acting as memory and writeback consumer; records observations.
    task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                          input logic [2:0] f3, input logic rd, input logic wr,
                          input int gnt_dly, input int rv_dly, input int stall, input bit noise);
        obs_req_seen = 0; obs_unstable = 0; obs_req_late = 0; obs_timeout = 0;
        obs_held_bad = 0; obs_rdy_busy = 0; obs_idle_ok = 0; obs_lat = 0;
        obs_addr = '0; obs_wdata = '0; obs_we = 1'b0; obs_wstrb = '0;
        @(negedge clk);
        ex_valid = 1'b1; ex_addr = a; ex_wdata = wd; ex_funct3 = f3; ex_rd = rd; ex_wr = wr;
        @(negedge clk);
        ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
        ex_funct3 = 3'($urandom_range(0, 7)); ex_rd = 1'($urandom); ex_wr = 1'($urandom);
        if (dmem_req) begin
            obs_req_seen = 1;
            obs_addr = dmem_addr; obs_we = dmem_we; obs_wdata = dmem_wdata; obs_wstrb = dmem_wstrb;
            if (ex_ready) obs_rdy_busy = 1;
            for (int i = 0; i < gnt_dly; i++) begin
                if (noise) begin dmem_rvalid = 1'b1; dmem_rdata = $urandom; end
                @(negedge clk);
                dmem_rvalid = 1'b0;
                if (!dmem_req || dmem_addr !== obs_addr || dmem_we !== obs_we ||
                    dmem_wdata !== obs_wdata || dmem_wstrb !== obs_wstrb || wb_valid)
                    obs_unstable = 1;
            end
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
            if (dmem_req) obs_req_late = 1;
            for (int i = 0; i < rv_dly; i++) begin
                @(negedge clk);
                if (dmem_req || wb_valid) obs_req_late = 1;
            end
            dmem_rvalid = 1'b1; dmem_rdata = rdv;
            @(negedge clk);
            dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        end
        while (!wb_valid && obs_lat < 20) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_timeout = !wb_valid;
        obs_wb_data = wb_data; obs_fault = fault;
        if (ex_ready || dmem_req) obs_rdy_busy = 1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!wb_valid || wb_data !== obs_wb_data || fault !== obs_fault || ex_ready || dmem_req)
                obs_held_bad = 1;
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        obs_idle_ok = ex_ready && !wb_valid && !dmem_req;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 0; ex_addr = '0; ex_wdata = '0; ex_funct3 = '0; ex_rd = 0; ex_wr = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0; wb_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, wb_valid, wb_data, fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wstrb=%b wbv=%b wbd=%h fault=%b, want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, wb_valid, wb_data, fault);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready);
        end
    endtask

    task automatic test_load_word();
        run_op(32'h100, 32'h0, 32'hDEADBEEF, 3'b010, 1, 0, 2, 0, 0, 0);
        checks++;
        if (obs_req_seen !== 1 || obs_addr !== 32'h100 || obs_we !== 0 || obs_wstrb !== 4'b0000) begin
            errors++; $display("FAIL lw_request: got req=%b addr=%h we=%b wstrb=%b want 1 00000100 0 0000",
                               obs_req_seen, obs_addr, obs_we, obs_wstrb);
        end
        checks++;
        if (obs_unstable || obs_req_late) begin
            errors++; $display("FAIL lw_handshake: got unstable=%b late_req=%b want 0 0", obs_unstable, obs_req_late);
        end
        checks++;
        if (obs_timeout || obs_wb_data !== 32'hDEADBEEF || obs_fault !== 0) begin
            errors++; $display("FAIL lw_result: got data=%h fault=%b timeout=%b want deadbeef 0 0",
                               obs_wb_data, obs_fault, obs_timeout);
        end
        checks++;
        if (!obs_idle_ok) begin
            errors++; $display("FAIL lw_return_idle: got %b want 1", obs_idle_ok);
        end
    endtask

    task automatic test_load_byte_ext();
        run_op(32'h103, 32'h0, 32'h80FF_FF7F, 3'b000, 1, 0, 0, 1, 0, 0);
        checks++;
        if (obs_wb_data !== 32'hFFFFFF80 || obs_fault !== 0 || obs_addr !== 32'h100) begin
            errors++; $display("FAIL lb_sign: got data=%h fault=%b addr=%h want ffffff80 0 00000100",
                               obs_wb_data, obs_fault, obs_addr);
        end
        run_op(32'h103, 32'h0, 32'h80FF_FF7F, 3'b100, 1, 0, 1, 0, 1, 0);
        checks++;
        if (obs_wb_data !== 32'h00000080 || obs_fault !== 0) begin
            errors++; $display("FAIL lbu_zero: got data=%h fault=%b want 00000080 0", obs_wb_data, obs_fault);
        end
    endtask

    task automatic test_store_half();
        run_op(32'h202, 32'h1234ABCD, 32'hFFFF_FFFF, 3'b001, 0, 1, 1, 0, 0, 0);
        checks++;
        if (obs_we !== 1 || obs_addr !== 32'h200 || obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCDABCD) begin
            errors++; $display("FAIL sh_request: got we=%b addr=%h wstrb=%b wdata=%h want 1 00000200 1100 abcdabcd",
                               obs_we, obs_addr, obs_wstrb, obs_wdata);
        end
        checks++;
        if (obs_wb_data !== 32'h0 || obs_fault !== 0) begin
            errors++; $display("FAIL sh_result: got data=%h fault=%b want 00000000 0", obs_wb_data, obs_fault);
        end
    endtask

    task automatic test_misaligned_fault();
        run_op(32'h101, 32'h0, 32'h0, 3'b010, 1, 0, 0, 0, 3, 0);
        checks++;
        if (obs_req_seen || obs_lat !== 0 || obs_timeout) begin
            errors++; $display("FAIL fault_no_access: got req=%b latency=%0d want 0 0", obs_req_seen, obs_lat);
        end
        checks++;
        if (obs_fault !== 1 || obs_wb_data !== 32'h0) begin
            errors++; $display("FAIL fault_result: got fault=%b data=%h want 1 00000000", obs_fault, obs_wb_data);
        end
        checks++;
        if (obs_held_bad || obs_rdy_busy) begin
            errors++; $display("FAIL fault_hold: got held_bad=%b ready_busy=%b want 0 0", obs_held_bad, obs_rdy_busy);
        end
    endtask

    task automatic test_passthrough();
        run_op(32'h55, 32'h0, 32'h0, 3'b000, 0, 0, 0, 0, 2, 0);
        checks++;
        if (obs_req_seen || obs_lat !== 0 || obs_wb_data !== 32'h55 || obs_fault !== 0) begin
            errors++; $display("FAIL passthrough: got req=%b latency=%0d data=%h fault=%b want 0 0 00000055 0",
                               obs_req_seen, obs_lat, obs_wb_data, obs_fault);
        end
        checks++;
        if (obs_rdy_busy || obs_held_bad || !obs_idle_ok) begin
            errors++; $display("FAIL passthrough_ready: got busy=%b held_bad=%b idle=%b want 0 0 1",
                               obs_rdy_busy, obs_held_bad, obs_idle_ok);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        ex_valid = 1'b1; ex_addr = 32'h300; ex_funct3 = 3'b010; ex_rd = 1; ex_wr = 0;
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL rst_wait_req: got %b want 1", dmem_req);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb, wb_valid, wb_data, fault} !== '0) begin
            errors++; $display("FAIL rst_wait_outputs: got req=%b wbv=%b wbd=%h fault=%b want all 0",
                               dmem_req, wb_valid, wb_data, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL rst_late_rvalid: got wbv=%b ready=%b req=%b want 0 1 0",
                                   wb_valid, ex_ready, dmem_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rdv, e_wb, e_daddr, e_dwdata;
        logic [2:0]  f3;
        logic        rd, wr, e_fault, e_mem;
        logic [3:0]  e_wstrb;
        int          kind;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind == 1) || (kind >= 2 && kind <= 5);
            wr = (kind == 1) || (kind >= 6);
            f3 = 3'($urandom_range(0, 7));
            if (kind >= 2 && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 2));
            a = $urandom; wd = $urandom; rdv = $urandom;
            model(a, wd, rdv, f3, rd, wr, e_fault, e_mem, e_wb, e_daddr, e_dwdata, e_wstrb);
            run_op(a, wd, rdv, f3, rd, wr, $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 2), 1'($urandom));
            checks++;
            if (obs_timeout || obs_fault !== e_fault || obs_wb_data !== e_wb) begin
                errors++; $display("FAIL rand_result op%0d f3=%b rd=%b wr=%b a=%h: got data=%h fault=%b want %h %b",
                                   n, f3, rd, wr, a, obs_wb_data, obs_fault, e_wb, e_fault);
            end
            checks++;
            if (obs_req_seen !== e_mem || (e_mem && (obs_addr !== e_daddr || obs_we !== wr ||
                obs_wstrb !== e_wstrb || (wr && obs_wdata !== e_dwdata)))) begin
                errors++; $display("FAIL rand_request op%0d: got req=%b addr=%h we=%b wstrb=%b wdata=%h want %b %h %b %b %h",
                                   n, obs_req_seen, obs_addr, obs_we, obs_wstrb, obs_wdata,
                                   e_mem, e_daddr, wr, e_wstrb, e_dwdata);
            end
            checks++;
            if (obs_unstable || obs_req_late || obs_held_bad || obs_rdy_busy || !obs_idle_ok || obs_lat !== 0) begin
                errors++; $display("FAIL rand_protocol op%0d: got unstable=%b late=%b held_bad=%b busy=%b idle=%b lat=%0d want 0 0 0 0 1 0",
                                   n, obs_unstable, obs_req_late, obs_held_bad, obs_rdy_busy, obs_idle_ok, obs_lat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_byte_ext();
        test_store_half();
        test_misaligned_fault();
        test_passthrough();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
